fwd_source_pipe: RTL
====================

Name: fwd_source_pipe

Overview:
- Producer side of the operand-forwarding interface.
- Owns the EX/MEM and MEM/WB writeback-tag and result registers, and drives the RegWrite, RdAddr and data signals that the forwarding mux logic consumes.
- Detects load-use hazards for the instruction in ID and raises a one-cycle stall request.
- Keeps writeback and stall performance counters.

Parameters:
- DATA_W, 32, result/data width.
- ADDR_W, 5, register address width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- stall_i  in  1  external pipeline hold (e.g. memory wait).
- flush_i  in  1  kill the instruction currently in EX.
- ex_valid_i  in  1  EX stage holds a real instruction.
- ex_regwrite_i  in  1  EX instruction writes a register.
- ex_memtoreg_i  in  1  EX instruction is a load.
- ex_rd_addr_i  in  ADDR_W  EX destination register.
- ex_alu_result_i  in  DATA_W  EX ALU result.
- mem_rdata_i  in  DATA_W  data-memory read data for the instruction in EX/MEM; combinational, same cycle.
- id_rs_addr_i, id_rt_addr_i  in  ADDR_W  source registers of the ID instruction.
- id_uses_rs_i, id_uses_rt_i  in  1  ID instruction reads rs / rt.
- EX_MEM_RegWrite_o  out  1  EX/MEM writes a register.
- EX_MEM_RdAddr_o  out  ADDR_W  EX/MEM destination.
- EX_MEM_Data_o  out  DATA_W  EX/MEM ALU result.
- EX_MEM_MemToReg_o  out  1  EX/MEM is a load.
- MEM_WB_RegWrite_o  out  1  MEM/WB writes a register.
- MEM_WB_RdAddr_o  out  ADDR_W  MEM/WB destination.
- MEM_WB_Data_o  out  DATA_W  writeback value.
- load_use_stall_o  out  1  stall ID/IF for one cycle and insert a bubble into ID/EX.
- wb_count_o  out  32  retired register writes.
- stall_count_o  out  16  stalled cycles.

Behaviour:
- Reset (rst_i low, asynchronous): every registered output, flush_pending and both counters go to 0.
- EX/MEM capture, on an edge with stall_i=0:
  - Effective flush = flush_i | flush_pending.
  - If effective flush is 1 or ex_valid_i=0: load a bubble (RegWrite=0, MemToReg=0, RdAddr=0, Data=0).
  - Otherwise:
    - RegWrite <= ex_regwrite_i & (ex_rd_addr_i != 0).
    - RdAddr <= ex_rd_addr_i when that RegWrite is 1, else 0.
    - MemToReg <= ex_memtoreg_i.
    - Data <= ex_alu_result_i.
- MEM/WB capture, on an edge with stall_i=0:
  - RegWrite <= EX_MEM_RegWrite_o.
  - RdAddr <= EX_MEM_RdAddr_o.
  - Data <= mem_rdata_i if EX_MEM_MemToReg_o, else EX_MEM_Data_o.
  - Latency: an EX result is visible on EX_MEM_* 1 edge later and on MEM_WB_* 2 edges later.
- Stall (stall_i=1): both stages hold their contents; counters other than stall_count_o hold.
- flush_pending:
  - Set when flush_i=1 and stall_i=1, so a flush during a stall is never lost.
  - Cleared on the first edge with stall_i=0, where it is applied as a flush.
  - A flush never touches MEM/WB.
- load_use_stall_o (combinational) is 1 when all of these hold, else 0:
  - ex_valid_i & ex_regwrite_i & ex_memtoreg_i;
  - ex_rd_addr_i != 0;
  - ((id_uses_rs_i & id_rs_addr_i == ex_rd_addr_i) | (id_uses_rt_i & id_rt_addr_i == ex_rd_addr_i));
  - flush_i=0.
- Load-use stall does not hold this block; the load advances into EX/MEM normally. Next cycle the EX instruction is the bubble, so the stall naturally lasts exactly 1 cycle.
- wb_count_o: +1 on each edge with stall_i=0 and MEM_WB_RegWrite_o=1; wraps modulo 2^32.
- stall_count_o: +1 on each edge with stall_i | load_use_stall_o; wraps modulo 2^16.
- Simultaneous events:
  - stall_i dominates flush_i (deferred through flush_pending).
  - flush_i suppresses load_use_stall_o.
  - rd=0 is never reported as a write.
- Reset mid-operation: in-flight stage contents are discarded immediately.

Test Plan:
- ALU add with rd=7, result 0x0000_0005, in a single cycle with no stall -> EX_MEM_RegWrite=1, RdAddr=7, Data=5 after edge 1; MEM_WB_* with Data=5 after edge 2; wb_count_o=1.
- Load with rd=3, mem_rdata_i=0xDEADBEEF, while ID reads rs=3 with id_uses_rs_i=1 -> load_use_stall_o=1 in that cycle; MEM_WB_Data=0xDEADBEEF two edges later; stall_count_o=1.
- Write with rd=0 and ex_regwrite_i=1 -> EX_MEM_RegWrite=0, RdAddr=0; load_use_stall_o=0 even if the load targets r0.
- flush_i=1 while stall_i=1 for 3 cycles, then stall released -> stages hold for 3 edges; the EX/MEM capture on the first free edge is a bubble; MEM/WB takes the prior EX/MEM contents; stall_count_o=3.
- rst_i pulsed low asynchronously between edges while both stages are valid -> all outputs 0 immediately, before the next clock edge; counters 0.
- 2^16 consecutive stall cycles -> stall_count_o wraps to 0; wb_count_o unchanged.

Source files
------------

// File: rtl/fwd_source_pipe_if.sv
// Operand-forwarding source bundle: EX/ID inputs into the producer and the
// EX/MEM, MEM/WB tag/data, stall and counter outputs it drives.
interface fwd_source_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              stall_i;
    logic              flush_i;
    logic              ex_valid_i;
    logic              ex_regwrite_i;
    logic              ex_memtoreg_i;
    logic [ADDR_W-1:0] ex_rd_addr_i;
    logic [DATA_W-1:0] ex_alu_result_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic [ADDR_W-1:0] id_rs_addr_i;
    logic [ADDR_W-1:0] id_rt_addr_i;
    logic              id_uses_rs_i;
    logic              id_uses_rt_i;

    logic              EX_MEM_RegWrite_o;
    logic [ADDR_W-1:0] EX_MEM_RdAddr_o;
    logic [DATA_W-1:0] EX_MEM_Data_o;
    logic              EX_MEM_MemToReg_o;
    logic              MEM_WB_RegWrite_o;
    logic [ADDR_W-1:0] MEM_WB_RdAddr_o;
    logic [DATA_W-1:0] MEM_WB_Data_o;
    logic              load_use_stall_o;
    logic [31:0]       wb_count_o;
    logic [15:0]       stall_count_o;

    modport master (
        input  stall_i, flush_i, ex_valid_i, ex_regwrite_i, ex_memtoreg_i,
               ex_rd_addr_i, ex_alu_result_i, mem_rdata_i,
               id_rs_addr_i, id_rt_addr_i, id_uses_rs_i, id_uses_rt_i,
        output EX_MEM_RegWrite_o, EX_MEM_RdAddr_o, EX_MEM_Data_o, EX_MEM_MemToReg_o,
               MEM_WB_RegWrite_o, MEM_WB_RdAddr_o, MEM_WB_Data_o,
               load_use_stall_o, wb_count_o, stall_count_o
    );

    modport slave (
        output stall_i, flush_i, ex_valid_i, ex_regwrite_i, ex_memtoreg_i,
               ex_rd_addr_i, ex_alu_result_i, mem_rdata_i,
               id_rs_addr_i, id_rt_addr_i, id_uses_rs_i, id_uses_rt_i,
        input  EX_MEM_RegWrite_o, EX_MEM_RdAddr_o, EX_MEM_Data_o, EX_MEM_MemToReg_o,
               MEM_WB_RegWrite_o, MEM_WB_RdAddr_o, MEM_WB_Data_o,
               load_use_stall_o, wb_count_o, stall_count_o
    );
endinterface

// File: rtl/fwd_source_pipe.sv
// Producer side of operand forwarding: EX/MEM and MEM/WB tag/result registers,
// load-use hazard detection and writeback/stall performance counters.
module fwd_source_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    fwd_source_pipe_if.master bus
);
    logic              r_ex_mem_regwrite;
    logic [ADDR_W-1:0] r_ex_mem_rd_addr;
    logic [DATA_W-1:0] r_ex_mem_data;
    logic              r_ex_mem_memtoreg;
    logic              r_mem_wb_regwrite;
    logic [ADDR_W-1:0] r_mem_wb_rd_addr;
    logic [DATA_W-1:0] r_mem_wb_data;
    logic              r_flush_pending;
    logic [31:0]       r_wb_count;
    logic [15:0]       r_stall_count;

    logic              w_flush_eff;
    logic              w_ex_writes;
    logic              w_load_use;
    logic [ADDR_W-1:0] w_src_addr [2];
    logic [1:0]        w_src_use;
    logic [1:0]        w_src_hit;

    assign w_src_addr[0] = bus.id_rs_addr_i;
    assign w_src_addr[1] = bus.id_rt_addr_i;
    assign w_src_use     = {bus.id_uses_rt_i, bus.id_uses_rs_i};

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign w_src_hit[gi] = w_src_use[gi] & (w_src_addr[gi] == bus.ex_rd_addr_i);
    end

    // r0 is hard-wired zero, so a write to it is never tracked or forwarded.
    assign w_ex_writes = bus.ex_regwrite_i & (bus.ex_rd_addr_i != '0);
    assign w_flush_eff = bus.flush_i | r_flush_pending;
    assign w_load_use  = bus.ex_valid_i & bus.ex_memtoreg_i & w_ex_writes
                       & (|w_src_hit) & ~bus.flush_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ex_mem_regwrite <= 1'b0;
            r_ex_mem_rd_addr  <= '0;
            r_ex_mem_data     <= '0;
            r_ex_mem_memtoreg <= 1'b0;
            r_mem_wb_regwrite <= 1'b0;
            r_mem_wb_rd_addr  <= '0;
            r_mem_wb_data     <= '0;
            r_flush_pending   <= 1'b0;
            r_wb_count        <= '0;
            r_stall_count     <= '0;
        end else begin
            if (bus.stall_i) begin
                // A flush arriving while held is remembered for the first free edge.
                if (bus.flush_i) begin
                    r_flush_pending <= 1'b1;
                end
            end else begin
                r_flush_pending <= 1'b0;
                if (w_flush_eff || !bus.ex_valid_i) begin
                    r_ex_mem_regwrite <= 1'b0;
                    r_ex_mem_rd_addr  <= '0;
                    r_ex_mem_data     <= '0;
                    r_ex_mem_memtoreg <= 1'b0;
                end else begin
                    r_ex_mem_regwrite <= w_ex_writes;
                    r_ex_mem_rd_addr  <= w_ex_writes ? bus.ex_rd_addr_i : '0;
                    r_ex_mem_data     <= bus.ex_alu_result_i;
                    r_ex_mem_memtoreg <= bus.ex_memtoreg_i;
                end
                r_mem_wb_regwrite <= r_ex_mem_regwrite;
                r_mem_wb_rd_addr  <= r_ex_mem_rd_addr;
                r_mem_wb_data     <= r_ex_mem_memtoreg ? bus.mem_rdata_i : r_ex_mem_data;
                if (r_mem_wb_regwrite) begin
                    r_wb_count <= r_wb_count + 32'd1;
                end
            end
            if (bus.stall_i || w_load_use) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign bus.EX_MEM_RegWrite_o = r_ex_mem_regwrite;
    assign bus.EX_MEM_RdAddr_o   = r_ex_mem_rd_addr;
    assign bus.EX_MEM_Data_o     = r_ex_mem_data;
    assign bus.EX_MEM_MemToReg_o = r_ex_mem_memtoreg;
    assign bus.MEM_WB_RegWrite_o = r_mem_wb_regwrite;
    assign bus.MEM_WB_RdAddr_o   = r_mem_wb_rd_addr;
    assign bus.MEM_WB_Data_o     = r_mem_wb_data;
    assign bus.load_use_stall_o  = w_load_use;
    assign bus.wb_count_o        = r_wb_count;
    assign bus.stall_count_o     = r_stall_count;
endmodule
